// File: rtl/lc3_io_pkg.sv
// Shared constants for the LC-3 memory-mapped board I/O devices.
// Holds the device register addresses (keyboard and display), the status
// register bit positions, the default debounce settings and the debounced
// key level type. Imported by the keyboard port now and by the display port
// later.
package lc3_io_pkg;

  localparam logic [15:0] LC3_KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] LC3_KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] LC3_DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] LC3_DDR_ADDR  = 16'hFE06;

  localparam int READY_BIT   = 15;
  localparam int IE_BIT      = 14;
  localparam int OVERRUN_BIT = 13;

  // 10 ms at 50 MHz; the counter width must hold DEFAULT_DEBOUNCE_CYCLES-1.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 20;

  // Pushbuttons on the board are active-low, so the encoding follows the pin.
  typedef enum logic {
    KEY_PRESSED  = 1'b0,
    KEY_RELEASED = 1'b1
  } key_level_e;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizer and debouncer for one active-low board pushbutton.
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  asynchronous active-high reset
//   key_n_i  raw pushbutton pin, active-low, asynchronous to clk_i
//   press_o  one-cycle pulse, high in the cycle before the debounced level
//            becomes pressed (so registers updating on that edge see it)
// A level change is accepted only after DEBOUNCE_CYCLES consecutive cycles
// of the synchronized input disagreeing with the debounced level.
module key_debouncer
  import lc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  key_level_e       level_q;
  key_level_e       level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchronizer plus the debounced level and its stability counter.
  // Synchronizer flops reset to the released level so a key held through
  // reset still has to travel the full synchronize-and-debounce path.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= KEY_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count cycles of disagreement; any agreeing cycle restarts the count, so
  // short glitches never reach the threshold. At the threshold the level
  // flips and the counter clears, so it never wraps. Only a flip towards
  // pressed produces a pulse.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_o = 1'b0;
    if (key_level_e'(sync2_q) != level_q) begin
      if (cnt_q == LAST_COUNT) begin
        level_d = key_level_e'(sync2_q);
        press_o = (key_level_e'(sync2_q) == KEY_PRESSED);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lc3_keyboard_port.sv
// LC-3 memory-mapped keyboard device (KBSR/KBDR).
// A debounced press of the pushbutton latches the switch byte into KBDR and
// sets KBSR ready; reading KBDR clears ready.
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   key_n_i      raw pushbutton, active-low
//   sw_data_i    character source (SW[7:0])
//   addr_i       bus address
//   rd_en_i      bus read strobe, one cycle per access
//   wr_en_i      bus write strobe
//   wr_data_i    bus write data
//   rd_data_o    read data, valid in the same cycle as rd_en_i
//   addr_hit_o   address selects KBSR or KBDR
//   irq_o        ready AND interrupt enable
//   ready_led_o  mirror of ready
// KBSR layout: {ready, ie, overrun, 13'b0}; ready is read-only, overrun is
// write-1-to-clear.
module lc3_keyboard_port
  import lc3_io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int          CNT_W           = DEFAULT_CNT_W,
  parameter logic [15:0] KBSR_ADDR       = LC3_KBSR_ADDR,
  parameter logic [15:0] KBDR_ADDR       = LC3_KBDR_ADDR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        key_n_i,
  input  logic [7:0]  sw_data_i,
  input  logic [15:0] addr_i,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [15:0] wr_data_i,
  output logic [15:0] rd_data_o,
  output logic        addr_hit_o,
  output logic        irq_o,
  output logic        ready_led_o
);

  logic       press;
  logic       ready_q, ready_d;
  logic       ie_q, ie_d;
  logic       overrun_q, overrun_d;
  logic [7:0] kbdr_q, kbdr_d;
  logic       kbsr_sel, kbdr_sel;
  logic       kbdr_read, kbsr_write;
  logic       unused_wr_data;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_debouncer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .key_n_i (key_n_i),
    .press_o (press)
  );

  assign kbsr_sel   = (addr_i == KBSR_ADDR);
  assign kbdr_sel   = (addr_i == KBDR_ADDR);
  assign kbdr_read  = rd_en_i && kbdr_sel;
  assign kbsr_write = wr_en_i && kbsr_sel;

  // Only the ie and overrun-clear bits of a KBSR write carry meaning.
  assign unused_wr_data = ^{wr_data_i[15], wr_data_i[12:0]};

  assign addr_hit_o  = kbsr_sel || kbdr_sel;
  assign irq_o       = ready_q && ie_q;
  assign ready_led_o = ready_q;

  // Read mux: zero unless a read strobe hits one of the two registers.
  always_comb begin
    rd_data_o = 16'h0000;
    if (rd_en_i && kbsr_sel) begin
      rd_data_o[READY_BIT]   = ready_q;
      rd_data_o[IE_BIT]      = ie_q;
      rd_data_o[OVERRUN_BIT] = overrun_q;
    end else if (rd_en_i && kbdr_sel) begin
      rd_data_o = {8'h00, kbdr_q};
    end
  end

  // Register next-state. Ordering matters: a KBDR read clears ready first so
  // that a press in the same cycle refills it as a fresh character rather
  // than an overrun, and the overrun set is evaluated after the KBSR write
  // so a set beats a simultaneous clear.
  always_comb begin
    ready_d   = ready_q;
    ie_d      = ie_q;
    overrun_d = overrun_q;
    kbdr_d    = kbdr_q;
    if (kbdr_read) begin
      ready_d = 1'b0;
    end
    if (kbsr_write) begin
      ie_d = wr_data_i[IE_BIT];
      if (wr_data_i[OVERRUN_BIT]) begin
        overrun_d = 1'b0;
      end
    end
    if (press) begin
      if (!ready_q || kbdr_read) begin
        kbdr_d  = sw_data_i;
        ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Device registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_q   <= 1'b0;
      ie_q      <= 1'b0;
      overrun_q <= 1'b0;
      kbdr_q    <= 8'h00;
    end else begin
      ready_q   <= ready_d;
      ie_q      <= ie_d;
      overrun_q <= overrun_d;
      kbdr_q    <= kbdr_d;
    end
  end

endmodule

// File: tb/tb_lc3_keyboard_port.sv
// Directed testbench for lc3_keyboard_port with a short debounce window.
module tb_lc3_keyboard_port;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;

  logic        clk;
  logic        reset;
  logic        keyN;
  logic [7:0]  swData;
  logic [15:0] addr;
  logic        rdEn;
  logic        wrEn;
  logic [15:0] wrData;
  logic [15:0] rdData;
  logic        addrHit;
  logic        irq;
  logic        readyLed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdEn;
    logic        wrEn;
    logic [15:0] addr;
    logic [15:0] wrData;
    logic [15:0] expRd;
    logic        expHit;
    logic        expIrq;
    logic        expLed;
  } vec_t;

  vec_t vecs[13];

  lc3_keyboard_port #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .key_n_i     (keyN),
    .sw_data_i   (swData),
    .addr_i      (addr),
    .rd_en_i     (rdEn),
    .wr_en_i     (wrEn),
    .wr_data_i   (wrData),
    .rd_data_o   (rdData),
    .addr_hit_o  (addrHit),
    .irq_o       (irq),
    .ready_led_o (readyLed)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one table vector onto the bus.
  task automatic applyStimulus(input vec_t v);
    rdEn   = v.rdEn;
    wrEn   = v.wrEn;
    addr   = v.addr;
    wrData = v.wrData;
  endtask

  // One-cycle bus read; data is captured before the edge that completes it.
  task automatic busRead(input logic [15:0] a, output logic [15:0] data);
    rdEn = 1'b1;
    addr = a;
    #1;
    data = rdData;
    tick();
    rdEn = 1'b0;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
    wrEn   = 1'b1;
    addr   = a;
    wrData = d;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [15:0] a, input logic [15:0] expected);
    logic [15:0] d;
    busRead(a, d);
    checkOutput(name, d, expected);
  endtask

  // Full press (held long enough to debounce) followed by a full release.
  task automatic pressKey(input logic [7:0] ch, input int lowCycles);
    swData = ch;
    keyN   = 1'b0;
    repeat (lowCycles) tick();
    keyN = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    reset  = 1'b1;
    keyN   = 1'b1;
    swData = 8'h00;
    addr   = 16'h0000;
    rdEn   = 1'b0;
    wrEn   = 1'b0;
    wrData = 16'h0000;

    // Register/bus behaviour with no key activity.
    vecs[0]  = '{1'b1, 1'b0, KBSR,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, KBDR,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'hFE04, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, KBSR,     16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, KBSR,     16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, KBDR,     16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, KBDR,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, KBSR,     16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, KBSR,     16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, KBSR,     16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, KBSR,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, KBDR,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'hFDFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

    // Power-on reset.
    tick();
    tick();
    checkOutput("por_irq", {15'b0, irq}, 16'h0000);
    checkOutput("por_led", {15'b0, readyLed}, 16'h0000);
    reset = 1'b0;
    tick();

    // Table-driven register access.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rd", i), rdData, vecs[i].expRd);
      checkOutput($sformatf("vec%0d_hit", i), {15'b0, addrHit}, {15'b0, vecs[i].expHit});
      checkOutput($sformatf("vec%0d_irq", i), {15'b0, irq}, {15'b0, vecs[i].expIrq});
      checkOutput($sformatf("vec%0d_led", i), {15'b0, readyLed}, {15'b0, vecs[i].expLed});
      tick();
      rdEn = 1'b0;
      wrEn = 1'b0;
    end

    // Clean press: ready appears on edge 6 after the first low sample.
    swData = 8'h41;
    keyN   = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 5) checkOutput("clean_led_e5", {15'b0, readyLed}, 16'h0000);
      if (e == 6) checkOutput("clean_led_e6", {15'b0, readyLed}, 16'h0001);
    end
    readCheck("clean_kbsr", KBSR, 16'h8000);
    readCheck("clean_kbdr", KBDR, 16'h0041);
    readCheck("clean_kbsr_after", KBSR, 16'h0000);
    repeat (15) tick();
    readCheck("held_no_repeat", KBSR, 16'h0000);
    keyN = 1'b1;
    repeat (10) tick();
    readCheck("release_no_event", KBSR, 16'h0000);

    // Glitch shorter than the debounce window.
    swData = 8'h55;
    keyN   = 1'b0;
    repeat (3) tick();
    keyN = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput($sformatf("glitch_led_c%0d", c), {15'b0, readyLed}, 16'h0000);
    end

    // Overrun keeps the oldest character.
    pressKey(8'h41, 8);
    pressKey(8'h42, 8);
    readCheck("ovr_kbsr", KBSR, 16'hA000);
    busWrite(KBSR, 16'h2000);
    readCheck("ovr_cleared", KBSR, 16'h8000);
    readCheck("ovr_kbdr", KBDR, 16'h0041);
    readCheck("ovr_drained", KBSR, 16'h0000);

    // Interrupt path.
    busWrite(KBSR, 16'h4000);
    pressKey(8'h5A, 8);
    checkOutput("int_irq", {15'b0, irq}, 16'h0001);
    readCheck("int_kbsr", KBSR, 16'hC000);
    readCheck("int_kbdr", KBDR, 16'h005A);
    checkOutput("int_irq_clear", {15'b0, irq}, 16'h0000);

    // Asynchronous reset mid-operation.
    pressKey(8'h33, 8);
    checkOutput("pre_reset_irq", {15'b0, irq}, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_irq", {15'b0, irq}, 16'h0000);
    checkOutput("async_led", {15'b0, readyLed}, 16'h0000);
    rdEn = 1'b1;
    addr = KBSR;
    #1;
    checkOutput("async_kbsr", rdData, 16'h0000);
    rdEn = 1'b0;
    #2;
    reset = 1'b0;
    tick();

    // Reset during debounce discards the partial count.
    swData = 8'h41;
    keyN   = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checkOutput($sformatf("rst_db_led_e%0d", e), {15'b0, readyLed}, (e == 6) ? 16'h0001 : 16'h0000);
    end
    repeat (4) tick();
    keyN = 1'b1;
    repeat (8) tick();

    // Collision: press edge coincides with a KBDR read while ready=1.
    swData = 8'h42;
    keyN   = 1'b0;
    repeat (5) tick();
    rdEn = 1'b1;
    addr = KBDR;
    #1;
    checkOutput("coll_rd_old", rdData, 16'h0041);
    tick();
    rdEn = 1'b0;
    keyN = 1'b1;
    repeat (8) tick();
    readCheck("coll_kbsr", KBSR, 16'h8000);
    readCheck("coll_kbdr", KBDR, 16'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
